tdm_mux: RTL and testbench
==========================

# tdm_mux

Registered N-channel, W-bit time-division multiplexer. It is the clocked successor to the combinational `muxN`. Each input channel has a valid/ready handshake, and the block merges them onto one registered output stream tagged with the source channel number. Channel selection is either manual (external select, as in `muxN`) or round-robin over the channels that are requesting. The block sits between per-channel producers and a single shared downstream consumer.

## Interface
- `N`, default 8: number of channels, N ≥ 2, not required to be a power of two.
- `W`, default 8: data width per channel.
- `SW`, default `$clog2(N)`: select/channel-tag width (localparam).
- `clk` input, 1: single clock, all state on rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `in_data` input, N*W: channel k occupies bits [k*W +: W].
- `in_valid` input, N: channel k holds a word.
- `in_ready` output, N: channel k's word is accepted this cycle (combinational).
- `mode` input, 1: 0 = MANUAL, 1 = ROUND_ROBIN.
- `sel` input, SW: channel to use in MANUAL mode.
- `out_data` output, W: registered data.
- `out_chan` output, SW: registered source channel of `out_data`.
- `out_valid` output, 1: output register holds a word.
- `out_ready` input, 1: consumer accepts the word this cycle.

## Operation
- **Output register.** One entry with state `EMPTY`/`FULL`; `out_valid` = (state == `FULL`).
- **Load enable.** `load_en = !out_valid || out_ready`.
- **Grant, MANUAL mode.**
  - Grant channel `sel` when `load_en && in_valid[sel] && sel < N`.
  - If `sel ≥ N`, no grant is made and all `in_ready` are 0.
- **Grant, ROUND_ROBIN mode.**
  - Grant the first k with `in_valid[k]`, scanning from pointer `ptr` upward and wrapping N-1 → 0.
  - A grant is made only when `load_en` is 1.
- **In-ready.** `in_ready` is one-hot on the granted channel, otherwise all zero.
  - `in_ready` never depends on `in_valid` of another channel in MANUAL mode.
- **On a grant.**
  - `out_data` ← `in_data[k]` and `out_chan` ← k.
  - State → `FULL`.
  - In ROUND_ROBIN mode only, `ptr` ← (k == N-1) ? 0 : k+1.
- **State transitions.**
  - `EMPTY` → `FULL` on a grant.
  - `FULL` → `EMPTY` on `out_ready` with no grant.
  - `FULL` → `FULL` on `out_ready` with a grant (back-to-back), or on `!out_ready` (hold; `out_data`/`out_chan` stable).
- **Mode changes.** `ptr` is unchanged in MANUAL mode and by mode switches. A mode change takes effect on the next grant decision and never disturbs a held word.
- **No requesters.** No grant; `ptr` unchanged.

## Timing
- **Reset values (`rst_n` low, asynchronous).** State `EMPTY`, `out_valid` = 0, `out_data` = 0, `out_chan` = 0, `ptr` = 0.
- **Reset mid-transfer.** A held word is discarded; no glitch beyond the asynchronous clear.
- **Latency.** Word accepted (`in_valid && in_ready`) at edge t appears with `out_valid` = 1 after edge t.
- **Throughput.** One word per cycle when `out_ready` is held at 1.
- **Back-pressure.** With `out_ready` = 0 and `out_valid` = 1, all `in_ready` are 0 and the output holds.
- **Fairness.** In ROUND_ROBIN mode with all channels continuously valid and `out_ready` = 1, grants cycle 0,1,…,N-1,0 with no repeats inside a window of N.

## Configuration
- **`TDM_MUX_PARITY_EN` defined.**
  - Adds output `out_parity` (1 bit), equal to the XOR of the loaded `in_data[k]`.
  - It is registered with `out_data` and resets to 0.
- **Not defined.** Port and logic are absent; behaviour is otherwise identical.

## Structure
- **Package `tdm_mux_pkg`.**
  - `typedef enum logic {MODE_MANUAL, MODE_RR} mode_t;`
  - `typedef enum logic {EMPTY, FULL} ostate_t;`
- **Sub-module `rr_pick`.**
  - Parameter N; inputs `req[N]` and `ptr`; outputs `found` and `idx`.
  - Combinational rotate-priority finder, instantiated once.
- **Top.** The FSM, registers and handshake logic live in `tdm_mux`.

## Test plan
- **Manual select.** N=8, W=8, MANUAL, `in_data` channel k = 8'h10+k, all valid, `sel`=5, `out_ready`=1.
  - Next cycle `out_data`=8'h15 and `out_chan`=5.
  - `in_ready` = 8'b0010_0000 continuously.
- **Round-robin scan.** ROUND_ROBIN, all valid, `out_ready`=1 from reset.
  - `out_chan` sequence is 0,1,…,7,0.
  - One word per cycle.
- **Sparse round-robin.** `in_valid`=8'b1000_0100, `ptr`=0.
  - Grants are 2, 7, 2, 7.
  - After granting 7, `ptr` wraps to 0.
- **Back-pressure.** Hold `out_ready`=0 for 3 cycles with `out_valid`=1.
  - `out_data`/`out_chan` are stable and `in_ready` = 0.
  - When `out_ready` rises, the next channel is loaded on the same edge the held word leaves.
- **Reset mid-operation.** Assert `rst_n`=0 mid-cycle while `FULL`.
  - `out_valid`, `out_data` and `out_chan` go to 0 immediately.
  - After release, the first round-robin grant is channel 0.
- **Non-power-of-two N with parity.** N=5 with `TDM_MUX_PARITY_EN`, MANUAL, `sel`=6.
  - No grant is made.
  - With `sel`=4 and `in_data[4]`=8'b1011_0001, `out_parity`=0.

Source files
------------

// File: rtl/tdm_mux_pkg.sv
// -----------------------------------------------------------------------------
// tdm_mux_pkg
// Shared types and helpers for the registered time-division multiplexer.
//   mode_t   : channel selection policy (manual select or round-robin)
//   ostate_t : occupancy of the single-entry output register
//   wrap_inc : increment an index, wrapping n-1 back to 0
// -----------------------------------------------------------------------------
package tdm_mux_pkg;

   typedef enum logic {MODE_MANUAL, MODE_RR} mode_t;

   typedef enum logic {EMPTY, FULL} ostate_t;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/tdm_mux_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority finder. Scans req starting at ptr, moving
// upward and wrapping from N-1 to 0, and reports the first requester.
// Ports:
//   req   [N-1:0]  in  : request vector
//   ptr   [SW-1:0] in  : starting position of the scan (must be < N)
//   found          out : at least one request is set
//   idx   [SW-1:0] out : first requesting index at or after ptr (0 if none)
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter  int N  = 8,
   localparam int SW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic          found,
   output logic [SW-1:0] idx
);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         int c;
         // Candidate position i steps after ptr, modulo N (N need not be 2^k).
         c = int'(ptr) + i;
         if (c >= N) begin
            c = c - N;
         end
         if (!found && req[c]) begin
            found = 1'b1;
            idx   = SW'(c);
         end
      end
   end

endmodule

// File: rtl/tdm_mux.sv
// -----------------------------------------------------------------------------
// tdm_mux
// Registered N-channel, W-bit time-division multiplexer. Per-channel
// valid/ready producers are merged into one registered output stream tagged
// with the source channel. Selection is manual (sel) or round-robin.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_data   [N*W-1:0] in     : channel k at bits [k*W +: W]
//   in_valid  [N-1:0]   in     : channel k holds a word
//   in_ready  [N-1:0]   out    : channel k's word is taken this cycle (comb)
//   mode                in     : 0 = manual, 1 = round-robin
//   sel       [SW-1:0]  in     : channel used in manual mode
//   out_data  [W-1:0]   out    : registered data
//   out_chan  [SW-1:0]  out    : registered source channel
//   out_valid           out    : output register holds a word
//   out_parity          out    : XOR of out_data (only with TDM_MUX_PARITY_EN)
//   out_ready           in     : consumer takes the word this cycle
// Build option: define TDM_MUX_PARITY_EN to add the out_parity port.
// -----------------------------------------------------------------------------
module tdm_mux
   import tdm_mux_pkg::*;
#(
   parameter  int N  = 8,
   parameter  int W  = 8,
   localparam int SW = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_valid,
   output logic [N-1:0]   in_ready,
   input  logic           mode,
   input  logic [SW-1:0]  sel,
   output logic [W-1:0]   out_data,
   output logic [SW-1:0]  out_chan,
   output logic           out_valid,
`ifdef TDM_MUX_PARITY_EN
   output logic           out_parity,
`endif
   input  logic           out_ready
);

   localparam int NPOW = 1 << SW;

   ostate_t       state_q, state_d;
   logic [W-1:0]  data_q,  data_d;
   logic [SW-1:0] chan_q,  chan_d;
   logic [SW-1:0] ptr_q,   ptr_d;
`ifdef TDM_MUX_PARITY_EN
   logic          parity_q, parity_d;
`endif

   logic [W-1:0]  chan_data [N];
   logic [NPOW-1:0] valid_ext;
   mode_t         mode_e;
   logic          load_en;
   logic          manual_ok;
   logic          rr_found;
   logic [SW-1:0] rr_idx;
   logic [SW-1:0] grant_idx;
   logic          grant;
   logic [W-1:0]  mux_data;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_chan
         assign chan_data[gi] = in_data[gi*W +: W];
         assign in_ready[gi]  = grant && (grant_idx == SW'(gi));
      end
   endgenerate

   assign mode_e  = mode_t'(mode);
   assign load_en = (state_q == EMPTY) || out_ready;

   // Zero-pad in_valid to the full select range so an out-of-range sel
   // (possible when N is not a power of two) reads a safe 0.
   always_comb begin
      valid_ext        = '0;
      valid_ext[N-1:0] = in_valid;
   end

   // Manual grant looks only at the selected channel's valid.
   assign manual_ok = (int'(sel) < N) && valid_ext[sel];

   rr_pick #(.N(N)) u_rr_pick (
      .req   (in_valid),
      .ptr   (ptr_q),
      .found (rr_found),
      .idx   (rr_idx)
   );

   assign grant_idx = (mode_e == MODE_RR) ? rr_idx : sel;
   assign grant     = load_en && ((mode_e == MODE_RR) ? rr_found : manual_ok);

   always_comb begin
      mux_data = '0;
      for (int k = 0; k < N; k++) begin
         if (grant_idx == SW'(k)) begin
            mux_data = chan_data[k];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      chan_d   = chan_q;
      ptr_d    = ptr_q;
`ifdef TDM_MUX_PARITY_EN
      parity_d = parity_q;
`endif
      if (grant) begin
         state_d  = FULL;
         data_d   = mux_data;
         chan_d   = grant_idx;
`ifdef TDM_MUX_PARITY_EN
         parity_d = ^mux_data;
`endif
         // The pointer only advances on round-robin grants; manual traffic
         // and mode switches leave it where it was.
         if (mode_e == MODE_RR) begin
            ptr_d = SW'(wrap_inc(int'(grant_idx), N));
         end
      end else if (out_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         data_q   <= '0;
         chan_q   <= '0;
         ptr_q    <= '0;
`ifdef TDM_MUX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         chan_q   <= chan_d;
         ptr_q    <= ptr_d;
`ifdef TDM_MUX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign out_valid  = (state_q == FULL);
   assign out_data   = data_q;
   assign out_chan   = chan_q;
`ifdef TDM_MUX_PARITY_EN
   assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_tdm_mux.sv
// -----------------------------------------------------------------------------
// tb_tdm_mux
// Directed bench for tdm_mux: an 8-channel instance for the main scenarios and
// a 5-channel instance for the non-power-of-two select range (and parity when
// TDM_MUX_PARITY_EN is defined).
// -----------------------------------------------------------------------------
module tb_tdm_mux;

   localparam int N  = 8;
   localparam int W  = 8;
   localparam int N5 = 5;

   logic           clk;
   logic           rst_n;

   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic           mode;
   logic [2:0]     sel;
   logic [W-1:0]   out_data;
   logic [2:0]     out_chan;
   logic           out_valid;
   logic           out_ready;

   logic [N5*W-1:0] in_data5;
   logic [N5-1:0]   in_valid5;
   logic [N5-1:0]   in_ready5;
   logic            mode5;
   logic [2:0]      sel5;
   logic [W-1:0]    out_data5;
   logic [2:0]      out_chan5;
   logic            out_valid5;
   logic            out_ready5;

   int total;
   int bad;

`ifdef TDM_MUX_PARITY_EN
   logic out_parity;
   logic out_parity5;
`endif

   tdm_mux #(.N(N), .W(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
`ifdef TDM_MUX_PARITY_EN
      .out_parity(out_parity),
`endif
      .out_ready (out_ready)
   );

   tdm_mux #(.N(N5), .W(W)) u_dut5 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data5),
      .in_valid  (in_valid5),
      .in_ready  (in_ready5),
      .mode      (mode5),
      .sel       (sel5),
      .out_data  (out_data5),
      .out_chan  (out_chan5),
      .out_valid (out_valid5),
`ifdef TDM_MUX_PARITY_EN
      .out_parity(out_parity5),
`endif
      .out_ready (out_ready5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Step one clock; inputs and checks happen 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = '0;
      in_valid5 = '0;
      out_ready = 1'b0;
      out_ready5 = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 3'd0) begin
         bad++;
         $display("FAIL reset_state: valid=%b data=%h chan=%0d expected 0/00/0",
                  out_valid, out_data, out_chan);
      end
      total++;
      if (out_valid5 !== 1'b0 || in_ready !== 8'h00) begin
         bad++;
         $display("FAIL reset_idle: valid5=%b in_ready=%b expected 0/00000000",
                  out_valid5, in_ready);
      end
      $display("reset: out_valid=%b out_data=%h out_chan=%0d", out_valid, out_data, out_chan);
   endtask

   task automatic test_manual();
      mode      = 1'b0;
      sel       = 3'd5;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      #1;
      for (int c = 0; c < 3; c++) begin
         total++;
         if (in_ready !== 8'b0010_0000) begin
            bad++;
            $display("FAIL manual_in_ready: cycle=%0d got=%b expected 00100000", c, in_ready);
         end
         tick();
         total++;
         if (out_valid !== 1'b1 || out_data !== 8'h15 || out_chan !== 3'd5) begin
            bad++;
            $display("FAIL manual_out: cycle=%0d valid=%b data=%h chan=%0d expected 1/15/5",
                     c, out_valid, out_data, out_chan);
         end
         $display("manual: cycle=%0d out_data=%h out_chan=%0d", c, out_data, out_chan);
      end
      // Other channels dropping valid must not affect the selected grant.
      in_valid = 8'b0010_0000;
      #1;
      total++;
      if (in_ready !== 8'b0010_0000) begin
         bad++;
         $display("FAIL manual_indep: got=%b expected 00100000", in_ready);
      end
      // Selected channel idle: no grant, register drains.
      in_valid = 8'b1101_1111;
      #1;
      total++;
      if (in_ready !== 8'h00) begin
         bad++;
         $display("FAIL manual_idle_sel: got=%b expected 00000000", in_ready);
      end
      tick();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL manual_drain: out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_rr_scan();
      int exp_chan;
      do_reset();
      mode      = 1'b1;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      #1;
      for (int g = 0; g < 9; g++) begin
         exp_chan = g % 8;
         total++;
         if (in_ready !== (8'h01 << exp_chan)) begin
            bad++;
            $display("FAIL rr_in_ready: grant=%0d got=%b expected chan %0d", g, in_ready, exp_chan);
         end
         tick();
         total++;
         if (out_valid !== 1'b1 || out_chan !== 3'(exp_chan) ||
             out_data !== 8'(8'h10 + exp_chan)) begin
            bad++;
            $display("FAIL rr_scan: grant=%0d valid=%b chan=%0d data=%h expected chan %0d",
                     g, out_valid, out_chan, out_data, exp_chan);
         end
         $display("rr_scan: grant=%0d out_chan=%0d out_data=%h", g, out_chan, out_data);
      end
   endtask

   task automatic test_sparse();
      int exp_seq [4];
      exp_seq = '{2, 7, 2, 7};
      do_reset();
      mode      = 1'b1;
      in_valid  = 8'b1000_0100;
      out_ready = 1'b1;
      for (int g = 0; g < 4; g++) begin
         tick();
         total++;
         if (out_valid !== 1'b1 || out_chan !== 3'(exp_seq[g])) begin
            bad++;
            $display("FAIL rr_sparse: grant=%0d valid=%b chan=%0d expected %0d",
                     g, out_valid, out_chan, exp_seq[g]);
         end
         $display("rr_sparse: grant=%0d out_chan=%0d", g, out_chan);
      end
   endtask

   task automatic test_back_pressure();
      do_reset();
      mode      = 1'b1;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      for (int c = 0; c < 3; c++) begin
         total++;
         if (in_ready !== 8'h00 || out_valid !== 1'b1 ||
             out_chan !== 3'd0 || out_data !== 8'h10) begin
            bad++;
            $display("FAIL backpressure_hold: cycle=%0d in_ready=%b valid=%b chan=%0d data=%h expected 00000000/1/0/10",
                     c, in_ready, out_valid, out_chan, out_data);
         end
         $display("backpressure: cycle=%0d out_chan=%0d out_data=%h", c, out_chan, out_data);
         tick();
      end
      out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 8'b0000_0010) begin
         bad++;
         $display("FAIL backpressure_release_ready: got=%b expected 00000010", in_ready);
      end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_chan !== 3'd1 || out_data !== 8'h11) begin
         bad++;
         $display("FAIL backpressure_release: valid=%b chan=%0d data=%h expected 1/1/11",
                  out_valid, out_chan, out_data);
      end
   endtask

   task automatic test_reset_mid();
      // The register is FULL with channel 1 from the previous scenario.
      out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 3'd0) begin
         bad++;
         $display("FAIL reset_mid: valid=%b data=%h chan=%0d expected 0/00/0",
                  out_valid, out_data, out_chan);
      end
      tick();
      rst_n     = 1'b1;
      mode      = 1'b1;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_chan !== 3'd0) begin
         bad++;
         $display("FAIL reset_mid_first_grant: valid=%b chan=%0d expected 1/0",
                  out_valid, out_chan);
      end
      $display("reset_mid: first grant out_chan=%0d", out_chan);
   endtask

   task automatic test_n5_parity();
      mode5      = 1'b0;
      sel5       = 3'd6;
      in_valid5  = 5'b1_1111;
      out_ready5 = 1'b1;
      in_data5   = {8'b1011_0001, 8'h33, 8'h22, 8'h11, 8'h00};
      #1;
      total++;
      if (in_ready5 !== 5'b0_0000) begin
         bad++;
         $display("FAIL n5_sel_oob_ready: got=%b expected 00000", in_ready5);
      end
      tick();
      total++;
      if (out_valid5 !== 1'b0) begin
         bad++;
         $display("FAIL n5_sel_oob_grant: out_valid=%b expected 0", out_valid5);
      end
      sel5 = 3'd4;
      #1;
      total++;
      if (in_ready5 !== 5'b1_0000) begin
         bad++;
         $display("FAIL n5_sel4_ready: got=%b expected 10000", in_ready5);
      end
      tick();
      total++;
      if (out_valid5 !== 1'b1 || out_data5 !== 8'b1011_0001 || out_chan5 !== 3'd4) begin
         bad++;
         $display("FAIL n5_sel4_out: valid=%b data=%h chan=%0d expected 1/b1/4",
                  out_valid5, out_data5, out_chan5);
      end
`ifdef TDM_MUX_PARITY_EN
      total++;
      if (out_parity5 !== 1'b0) begin
         bad++;
         $display("FAIL n5_parity_even: got=%b expected 0", out_parity5);
      end
      in_data5[4*W +: W] = 8'b1011_0011;
      tick();
      total++;
      if (out_parity5 !== 1'b1) begin
         bad++;
         $display("FAIL n5_parity_odd: got=%b expected 1", out_parity5);
      end
`endif
      $display("n5: out_chan=%0d out_data=%h", out_chan5, out_data5);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      rst_n      = 1'b0;
      mode       = 1'b0;
      sel        = '0;
      in_valid   = '0;
      out_ready  = 1'b0;
      mode5      = 1'b0;
      sel5       = '0;
      in_valid5  = '0;
      out_ready5 = 1'b0;
      in_data5   = '0;
      for (int k = 0; k < N; k++) begin
         in_data[k*W +: W] = 8'(8'h10 + k);
      end

      test_reset();
      test_manual();
      test_rr_scan();
      test_sparse();
      test_back_pressure();
      test_reset_mid();
      test_n5_parity();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
